arbiter_req_bank: RTL and testbench

Requester-side companion to the N-bit daisy-chain priority arbiter: N independent requester channels that each accept a job (a burst length), drive their request line, hold it until the burst has been served, then release and report completion. The block sits between the job sources and the combinational arbiter. It drives the arbiter's request vector `r` and consumes its grant vector `g`. It also checks that the arbiter obeys the grant protocol.

---
 rtl/arbiter_req_bank.sv | 68 ++++++
 tb/tb_arbiter_req_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_req_bank.sv
// arbiter_req_bank: per-channel burst requesters feeding a priority arbiter, with grant-protocol checking
module arbiter_req_bank #(
  parameter int N = 8,
  parameter int LENW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:N-1]      start,
  input  logic [N*LENW-1:0] len,
  output logic [0:N-1]      r,
  input  logic [0:N-1]      g,
  output logic [0:N-1]      busy,
  output logic [0:N-1]      done,
  output logic [7:0]        preempt_cnt,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, REQ, OWN} state_t;
  logic [0:N-1] lost;
  logic [7:0]   lost_n;
  logic [8:0]   pc_sum;
  logic         multi, stray, starve;
  for (genvar c = 0; c < N; c++) begin : ch
    state_t         st;
    logic [LENW-1:0] rem, l;
    logic           done_q;
    assign l = len[c*LENW +: LENW];
    // OWN means the previous edge was granted, so OWN with no grant is a grant-loss event
    assign lost[c] = st == OWN && !g[c];
    assign r[c]    = st != IDLE;
    assign busy[c] = st != IDLE;
    assign done[c] = done_q;
    // job acceptance, grant-driven countdown and fall-back to REQ when preempted
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st     <= IDLE;
        rem    <= '0;
        done_q <= 1'b0;
      end else if (st == IDLE) begin
        if (start[c]) rem <= l;
        st     <= start[c] && l != '0 ? REQ : IDLE;
        done_q <= start[c] && l == '0;
      end else if (g[c]) begin
        rem    <= rem - 1'b1;
        st     <= rem == LENW'(1) ? IDLE : OWN;
        done_q <= rem == LENW'(1);
      end else begin
        st     <= REQ;
        done_q <= 1'b0;
      end
  end
  // number of channels losing grant on this edge
  always_comb begin
    lost_n = '0;
    for (int k = 0; k < N; k++) lost_n = lost_n + 8'(lost[k]);
  end
  assign pc_sum = {1'b0, preempt_cnt} + {1'b0, lost_n};
  assign multi  = (g & (g - N'(1))) != '0;
  assign stray  = (g & ~r) != '0;
  assign starve = r != '0 && g == '0;
  // saturating preemption counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) preempt_cnt <= '0;
    else preempt_cnt <= pc_sum[8] ? 8'hFF : pc_sum[7:0];
  // sticky flag for any arbiter grant-protocol violation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) proto_err <= 1'b0;
    else proto_err <= proto_err | multi | stray | starve;
endmodule

// File: tb/tb_arbiter_req_bank.sv
// tb_arbiter_req_bank: directed and random checks of the requester bank against a job-level model
module tb_arbiter_req_bank;
  localparam int N = 8;
  localparam int LENW = 4;
  logic clk = 1'b0, rst_n = 1'b0, ovr = 1'b0;
  logic [0:N-1] start = '0, r, g, busy, done, g_ovr = '0, acc;
  logic [N*LENW-1:0] len = '0;
  logic [7:0] preempt_cnt;
  logic proto_err;
  int total = 0, bad = 0;
  int cnt, seen, r5, d1, d5, dn;
  logic [0:N-1] m_act = '0, m_own = '0, m_done = '0;
  int m_rem [N];
  int m_pc = 0;
  logic m_pe = 1'b0;

  always #5 clk = ~clk;

  arbiter_req_bank #(.N(N), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .r(r), .g(g),
    .busy(busy), .done(done), .preempt_cnt(preempt_cnt), .proto_err(proto_err)
  );

  function automatic logic [0:N-1] arb(input logic [0:N-1] v);
    logic [0:N-1] o;
    o = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) begin o = '0; o[i] = 1'b1; end
    return o;
  endfunction

  always_comb g = ovr ? g_ovr : arb(r);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = '0; m_own = '0; m_done = '0; m_pc = 0; m_pe = 1'b0;
    for (int i = 0; i < N; i++) m_rem[i] = 0;
  endtask

  task automatic model_step();
    logic [0:N-1] eg;
    int ng, lost, l;
    eg = ovr ? g_ovr : arb(m_act);
    ng = 0;
    for (int i = 0; i < N; i++) ng += int'(eg[i]);
    if (ng > 1 || (eg & ~m_act) != '0 || (m_act != '0 && eg == '0)) m_pe = 1'b1;
    lost = 0;
    for (int i = 0; i < N; i++) begin
      m_done[i] = 1'b0;
      l = int'(len[i*LENW +: LENW]);
      if (!m_act[i]) begin
        if (start[i]) begin
          if (l == 0) m_done[i] = 1'b1;
          else begin m_act[i] = 1'b1; m_rem[i] = l; m_own[i] = 1'b0; end
        end
      end else if (eg[i]) begin
        m_rem[i]--;
        m_own[i] = 1'b1;
        if (m_rem[i] == 0) begin m_act[i] = 1'b0; m_own[i] = 1'b0; m_done[i] = 1'b1; end
      end else begin
        if (m_own[i]) lost++;
        m_own[i] = 1'b0;
      end
    end
    m_pc = m_pc + lost > 255 ? 255 : m_pc + lost;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    chk("cyc_r", r, m_act);
    chk("cyc_busy", busy, m_act);
    chk("cyc_done", done, m_done);
    chk("cyc_preempt", preempt_cnt, m_pc);
    chk("cyc_proto", proto_err, m_pe);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input int ch, input int l);
    start[ch] = 1'b1;
    len[ch*LENW +: LENW] = LENW'(l);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    tick();
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_preempt", preempt_cnt, 0);
    chk("rst_proto", proto_err, 0);
    rst_n = 1'b1;
    tick();
    go(3, 5); tick(); start = '0;
    cnt = 0; seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (r == 8'b0001_0000) cnt++;
      if (done[3]) begin seen = 1; chk("single_r_at_done", r, 0); end
      else tick();
    end
    chk("single_rcnt", cnt, 5);
    chk("single_done_seen", seen, 1);
    chk("single_preempt", preempt_cnt, 0);
    chk("single_proto", proto_err, 0);
    tick();
    chk("single_done_pulse", done, 0);
    go(5, 6); tick(); start = '0;
    r5 = 0; d1 = 0; d5 = 0;
    for (int k = 1; k <= 20 && d5 == 0; k++) begin
      r5 += int'(r[5]);
      if (done[1] && d1 == 0) d1 = k;
      if (done[5]) d5 = k;
      start = '0;
      if (k == 2) go(1, 3);
      tick();
    end
    chk("preempt_done1_cycle", d1, 6);
    chk("preempt_done5_cycle", d5, 10);
    chk("preempt_r5_cycles", r5, 9);
    chk("preempt_cnt", preempt_cnt, 1);
    for (int i = 0; i < N; i++) go(i, 1);
    tick(); start = '0;
    for (int k = 1; k <= 9; k++) begin
      chk("all_r", r, k <= 8 ? 32'hFF >> (k - 1) : 0);
      chk("all_done", done, k >= 2 ? 32'h80 >> (k - 2) : 0);
      tick();
    end
    chk("all_proto", proto_err, 0);
    go(2, 0); tick(); start = '0;
    chk("len0_done", done, 32'h20);
    chk("len0_r", r, 0);
    tick();
    chk("len0_done_clear", done, 0);
    go(7, 15); tick(); start = '0;
    cnt = 0; seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      if (r[7]) cnt++;
      if (done[7]) seen = 1;
      else tick();
    end
    chk("len15_rcnt", cnt, 15);
    chk("len15_done_seen", seen, 1);
    tick();
    go(4, 3); tick(); start = '0; tick();
    go(4, 5); tick(); start = '0;
    dn = 0;
    repeat (15) begin dn += int'(done[4]); tick(); end
    chk("busy_start_dones", dn, 1);
    chk("busy_start_idle", busy[4], 0);
    go(0, 6); tick(); start = '0;
    repeat (3) tick();
    chk("midrst_pre_r", r, 32'h80);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_r", r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_preempt", preempt_cnt, 0);
    chk("midrst_proto", proto_err, 0);
    @(negedge clk) rst_n = 1'b1;
    acc = '0;
    repeat (8) begin tick(); acc |= done | r; end
    chk("midrst_no_done", acc, 0);
    go(0, 8); go(1, 8); tick(); start = '0;
    chk("proto_r", r, 32'hC0);
    g_ovr = 8'b1100_0000; ovr = 1'b1;
    #1 chk("proto_multi_before", proto_err, 0);
    tick();
    chk("proto_multi_set", proto_err, 1);
    ovr = 1'b0;
    repeat (3) tick();
    chk("proto_multi_held", proto_err, 1);
    hard_reset();
    chk("proto_cleared", proto_err, 0);
    tick();
    g_ovr = 8'b0000_1000; ovr = 1'b1;
    #1 chk("proto_stray_before", proto_err, 0);
    tick();
    chk("proto_stray_set", proto_err, 1);
    ovr = 1'b0;
    tick();
    chk("proto_stray_held", proto_err, 1);
    hard_reset();
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) go(i, int'($urandom_range(0, 15)));
        else start[i] = 1'b0;
      tick();
    end
    start = '0;
    repeat (150) tick();
    chk("rand_drained", r, 0);
    hard_reset();
    repeat (1200) begin
      go(0, 1);
      go(7, int'($urandom_range(4, 15)));
      tick();
    end
    start = '0;
    chk("sat_preempt", preempt_cnt, 255);
    repeat (150) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
